// File: rtl/text_pkg.sv
// Shared constants and enumerations for the text-mode character RAM arbiter.
package text_pkg;

  localparam int unsigned TEXT_COLS = 60;
  localparam int unsigned TEXT_ROWS = 34;
  localparam int unsigned CELLS     = TEXT_COLS * TEXT_ROWS;
  localparam int unsigned ADDR_W    = 11;
  localparam int unsigned DATA_W    = 8;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CLR_WAIT,
    ST_CLR_RUN
  } arb_state_e;

  typedef enum logic [1:0] {
    GNT_NONE,
    GNT_RD,
    GNT_CLR,
    GNT_HOST
  } grant_e;

endpackage

// File: rtl/text_ram_arbiter_if.sv
// Bus bundle for the text RAM arbiter: display read, host write, clear control and RAM port.
interface text_ram_arbiter_if #(
  parameter int unsigned ADDR_W = 11,
  parameter int unsigned DATA_W = 8
);

  logic              i_rd_en;
  logic [ADDR_W-1:0] i_rd_addr;
  logic [DATA_W-1:0] o_rd_data;
  logic              i_wr_valid;
  logic [ADDR_W-1:0] i_wr_addr;
  logic [DATA_W-1:0] i_wr_data;
  logic              o_wr_ready;
  logic              i_clr_start;
  logic [DATA_W-1:0] i_clr_char;
  logic              o_clr_busy;
  logic              o_ram_ce;
  logic              o_ram_we;
  logic [ADDR_W-1:0] o_ram_addr;
  logic [DATA_W-1:0] o_ram_wdata;
  logic [DATA_W-1:0] i_ram_rdata;

  modport slave (
    input  i_rd_en, i_rd_addr, i_wr_valid, i_wr_addr, i_wr_data,
           i_clr_start, i_clr_char, i_ram_rdata,
    output o_rd_data, o_wr_ready, o_clr_busy,
           o_ram_ce, o_ram_we, o_ram_addr, o_ram_wdata
  );

  modport master (
    output i_rd_en, i_rd_addr, i_wr_valid, i_wr_addr, i_wr_data,
           i_clr_start, i_clr_char, i_ram_rdata,
    input  o_rd_data, o_wr_ready, o_clr_busy,
           o_ram_ce, o_ram_we, o_ram_addr, o_ram_wdata
  );

endinterface

// File: rtl/text_wr_skid.sv
// One-entry host write buffer: accepts on valid&ready, empties on the retire strobe.
module text_wr_skid #(
  parameter int unsigned ADDR_W = 11,
  parameter int unsigned DATA_W = 8
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              valid_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic              accept_en_i,
  input  logic              retire_i,
  output logic              ready_o,
  output logic              full_o,
  output logic [ADDR_W-1:0] addr_o,
  output logic [DATA_W-1:0] data_o
);

  logic              full_q, full_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] data_q, data_d;

  assign ready_o = !full_q && accept_en_i;

  // Accept and retire are exclusive: ready is low whenever the entry is occupied.
  always_comb begin
    full_d = full_q;
    addr_d = addr_q;
    data_d = data_q;
    if (valid_i && ready_o) begin
      full_d = 1'b1;
      addr_d = addr_i;
      data_d = data_i;
    end else if (retire_i) begin
      full_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      full_q <= 1'b0;
      addr_q <= '0;
      data_q <= '0;
    end else begin
      full_q <= full_d;
      addr_q <= addr_d;
      data_q <= data_d;
    end
  end

  assign full_o = full_q;
  assign addr_o = addr_q;
  assign data_o = data_q;

endmodule

// File: rtl/text_ram_arbiter.sv
// Fixed-priority arbiter for the character RAM: display read > clear fill > buffered host write.
// Clear engine is built only when TEXT_ARB_CLEAR_EN is defined.
module text_ram_arbiter #(
  parameter int unsigned ADDR_W = text_pkg::ADDR_W,
  parameter int unsigned DATA_W = text_pkg::DATA_W,
  parameter int unsigned CELLS  = text_pkg::CELLS
) (
  input  logic              i_clk,
  input  logic              i_rstn,
  text_ram_arbiter_if.slave bus
);

  import text_pkg::*;

  arb_state_e        state_q;
  grant_e            grant;
  logic              buf_full;
  logic              buf_ready;
  logic              retire;
  logic [ADDR_W-1:0] buf_addr;
  logic [DATA_W-1:0] buf_data;
  logic              ram_ce;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata;

  text_wr_skid #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_skid (
    .clk_i       (i_clk),
    .rst_ni      (i_rstn),
    .valid_i     (bus.i_wr_valid),
    .addr_i      (bus.i_wr_addr),
    .data_i      (bus.i_wr_data),
    .accept_en_i (state_q == ST_IDLE),
    .retire_i    (retire),
    .ready_o     (buf_ready),
    .full_o      (buf_full),
    .addr_o      (buf_addr),
    .data_o      (buf_data)
  );

  assign bus.o_wr_ready = buf_ready;
  assign bus.o_rd_data  = bus.i_ram_rdata;

  always_comb begin
    grant = GNT_NONE;
    if (bus.i_rd_en) begin
      grant = GNT_RD;
    end else if (state_q == ST_CLR_RUN) begin
      grant = GNT_CLR;
    end else if (buf_full) begin
      grant = GNT_HOST;
    end
  end

  assign retire = (grant == GNT_HOST);

`ifdef TEXT_ARB_CLEAR_EN
  logic              busy_q;
  logic [ADDR_W-1:0] cnt_q;
  logic [DATA_W-1:0] fill_q;

  // CLR_WAIT holds off the fill until any write accepted before the clear has retired.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_q <= ST_IDLE;
      busy_q  <= 1'b0;
      cnt_q   <= '0;
      fill_q  <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (bus.i_clr_start) begin
            fill_q  <= bus.i_clr_char;
            state_q <= ST_CLR_WAIT;
            busy_q  <= 1'b1;
          end
        end
        ST_CLR_WAIT: begin
          if (!buf_full) begin
            state_q <= ST_CLR_RUN;
          end
        end
        ST_CLR_RUN: begin
          if (grant == GNT_CLR) begin
            if (cnt_q == ADDR_W'(CELLS - 1)) begin
              cnt_q   <= '0;
              state_q <= ST_IDLE;
              busy_q  <= 1'b0;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.o_clr_busy = busy_q;
`else
  logic unused_clr;

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= ST_IDLE;
    end
  end

  assign bus.o_clr_busy = 1'b0;
  assign unused_clr     = ^{bus.i_clr_start, bus.i_clr_char, 32'(CELLS)};
`endif

  always_comb begin
    ram_ce    = 1'b0;
    ram_we    = 1'b0;
    ram_addr  = '0;
    ram_wdata = '0;
    case (grant)
      GNT_RD: begin
        ram_ce   = 1'b1;
        ram_addr = bus.i_rd_addr;
      end
`ifdef TEXT_ARB_CLEAR_EN
      GNT_CLR: begin
        ram_ce    = 1'b1;
        ram_we    = 1'b1;
        ram_addr  = cnt_q;
        ram_wdata = fill_q;
      end
`endif
      GNT_HOST: begin
        ram_ce    = 1'b1;
        ram_we    = 1'b1;
        ram_addr  = buf_addr;
        ram_wdata = buf_data;
      end
      default: begin
      end
    endcase
  end

  assign bus.o_ram_ce    = ram_ce;
  assign bus.o_ram_we    = ram_we;
  assign bus.o_ram_addr  = ram_addr;
  assign bus.o_ram_wdata = ram_wdata;

endmodule

// File: tb/tb_text_ram_arbiter.sv
// Randomized bench for text_ram_arbiter with a queue-based reference model; honours TEXT_ARB_CLEAR_EN.
module tb_text_ram_arbiter;

  localparam int unsigned CELLS = 2040;

  logic clk = 1'b0;
  logic rstn;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   busy_writes = 0;

  always #5 clk = ~clk;

  text_ram_arbiter_if #(.ADDR_W(11), .DATA_W(8)) bus ();

  text_ram_arbiter #(.ADDR_W(11), .DATA_W(8), .CELLS(CELLS)) dut (
    .i_clk  (clk),
    .i_rstn (rstn),
    .bus    (bus)
  );

  logic [7:0] mem [2048];
  always @(posedge clk) begin
    if (bus.o_ram_ce) begin
      if (bus.o_ram_we) mem[bus.o_ram_addr] <= bus.o_ram_wdata;
      else              bus.i_ram_rdata     <= mem[bus.o_ram_addr];
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: pending host writes, clear phase (0 none, 1 waiting, 2 filling), shadow memory.
  typedef struct { logic [10:0] a; logic [7:0] d; } wr_t;
  wr_t        q[$];
  int         phase = 0;
  int         cidx  = 0;
  logic [7:0] fill  = '0;
  bit         rd_pend = 1'b0;
  logic [7:0] rd_exp;
  bit         known [2048];
  logic [7:0] shadow [2048];

  always @(negedge clk) begin : model
    bit          e_ce, e_we, e_rdy, e_busy, q_empty0;
    logic [10:0] e_a;
    logic [7:0]  e_d;
    int          ph0;
    if (!rstn) begin
      q.delete();
      phase   = 0;
      cidx    = 0;
      fill    = '0;
      rd_pend = 1'b0;
    end else begin
      if (rd_pend) chk("rd_data", bus.o_rd_data, rd_exp);
      rd_pend  = 1'b0;
      ph0      = phase;
      q_empty0 = (q.size() == 0);
      e_rdy    = q_empty0 && (ph0 == 0);
      e_busy   = (ph0 != 0);
      e_ce = 1'b0; e_we = 1'b0; e_a = '0; e_d = '0;
      if (bus.i_rd_en) begin
        e_ce = 1'b1;
        e_a  = bus.i_rd_addr;
        if (known[e_a]) begin
          rd_pend = 1'b1;
          rd_exp  = shadow[e_a];
        end
      end else if (ph0 == 2) begin
        e_ce = 1'b1; e_we = 1'b1; e_a = cidx[10:0]; e_d = fill;
        if (cidx == CELLS - 1) begin
          phase = 0;
          cidx  = 0;
        end else begin
          cidx++;
        end
      end else if (!q_empty0) begin
        e_ce = 1'b1; e_we = 1'b1; e_a = q[0].a; e_d = q[0].d;
        void'(q.pop_front());
      end
      if (e_we) begin
        shadow[e_a] = e_d;
        known[e_a]  = 1'b1;
      end
      chk("ram_ce", bus.o_ram_ce, e_ce);
      chk("ram_we", bus.o_ram_we, e_we);
      chk("wr_ready", bus.o_wr_ready, e_rdy);
      chk("clr_busy", bus.o_clr_busy, e_busy);
      if (e_ce) chk("ram_addr", bus.o_ram_addr, e_a);
      if (e_we) chk("ram_wdata", bus.o_ram_wdata, e_d);
      if (ph0 == 1 && q_empty0) phase = 2;
      if (bus.i_wr_valid && e_rdy) q.push_back('{bus.i_wr_addr, bus.i_wr_data});
`ifdef TEXT_ARB_CLEAR_EN
      if (ph0 == 0 && bus.i_clr_start) begin
        phase = 1;
        fill  = bus.i_clr_char;
      end
`endif
    end
  end

  always @(negedge clk) begin
    if (rstn && bus.o_ram_ce && bus.o_ram_we && bus.o_clr_busy) busy_writes++;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.i_rd_en     = 1'b0;
    bus.i_wr_valid  = 1'b0;
    bus.i_clr_start = 1'b0;
  endtask

  task automatic host_wr(input logic [10:0] a, input logic [7:0] d);
    int n = 0;
    bus.i_wr_valid = 1'b1;
    bus.i_wr_addr  = a;
    bus.i_wr_data  = d;
    while (!bus.o_wr_ready && n < 20000) begin
      step();
      n++;
    end
    chk("wr_accept", bus.o_wr_ready, 1);
    step();
    bus.i_wr_valid = 1'b0;
  endtask

  task automatic wait_idle(input bit rand_rd);
    int n = 0;
    while (bus.o_clr_busy && n < 20000) begin
      bus.i_rd_en   = rand_rd ? 1'($urandom_range(0, 1)) : 1'b0;
      bus.i_rd_addr = 11'($urandom_range(0, 2047));
      step();
      n++;
    end
    bus.i_rd_en = 1'b0;
    chk("clr_done", bus.o_clr_busy, 0);
    repeat (3) step();
  endtask

  task automatic read_lit(input string name, input logic [10:0] a, input int exp);
    bus.i_rd_en   = 1'b1;
    bus.i_rd_addr = a;
    step();
    bus.i_rd_en = 1'b0;
    chk(name, bus.o_rd_data, exp);
  endtask

  initial begin
    #3ms;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int b0;
    rstn            = 1'b0;
    bus.i_rd_addr   = '0;
    bus.i_wr_addr   = '0;
    bus.i_wr_data   = '0;
    bus.i_clr_char  = '0;
    idle_inputs();
    repeat (3) step();
    chk("reset_ready", bus.o_wr_ready, 1);
    chk("reset_busy", bus.o_clr_busy, 0);
    chk("reset_ce", bus.o_ram_ce, 0);
    rstn = 1'b1;
    step();

    // Display read of a host-written cell.
    host_wr(11'd5, 8'h41);
    repeat (2) step();
    read_lit("read_addr5", 11'd5, 8'h41);

    // Host write held off by continuous reads.
    bus.i_rd_en    = 1'b1;
    bus.i_rd_addr  = 11'd100;
    bus.i_wr_valid = 1'b1;
    bus.i_wr_addr  = 11'd12;
    bus.i_wr_data  = 8'h58;
    step();
    bus.i_wr_valid = 1'b0;
    chk("ready_after_accept", bus.o_wr_ready, 0);
    repeat (9) step();
    bus.i_rd_en = 1'b0;
    #1;
    chk("held_wr_ce", bus.o_ram_ce, 1);
    chk("held_wr_we", bus.o_ram_we, 1);
    chk("held_wr_addr", bus.o_ram_addr, 12);
    chk("held_wr_data", bus.o_ram_wdata, 8'h58);
    repeat (2) step();
    read_lit("read_addr12", 11'd12, 8'h58);

`ifdef TEXT_ARB_CLEAR_EN
    // Buffered write pending when the clear starts, then a full clear.
    bus.i_rd_en   = 1'b1;
    bus.i_rd_addr = 11'd200;
    host_wr(11'd3, 8'h7A);
    b0 = busy_writes;
    bus.i_clr_start = 1'b1;
    bus.i_clr_char  = 8'h20;
    step();
    bus.i_clr_start = 1'b0;
    chk("busy_rise", bus.o_clr_busy, 1);
    wait_idle(1'b1);
    chk("clear_write_count", busy_writes - b0, CELLS + 1);
    read_lit("order_addr3", 11'd3, 8'h20);
    read_lit("fill_last", 11'd2039, 8'h20);
`else
    bus.i_clr_start = 1'b1;
    bus.i_clr_char  = 8'h20;
    step();
    bus.i_clr_start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("noclr_busy", bus.o_clr_busy, 0);
      chk("noclr_ce", bus.o_ram_ce, 0);
      step();
    end
    host_wr(11'd3, 8'h7A);
    repeat (2) step();
    read_lit("noclr_addr3", 11'd3, 8'h7A);
`endif

    // Random traffic.
    for (int i = 0; i < 6000; i++) begin
      bus.i_rd_en     = ($urandom_range(0, 9) < 6);
      bus.i_rd_addr   = 11'($urandom_range(0, 2047));
      bus.i_wr_valid  = ($urandom_range(0, 9) < 3);
      bus.i_wr_addr   = 11'($urandom_range(0, 2047));
      bus.i_wr_data   = 8'($urandom);
      bus.i_clr_start = ($urandom_range(0, 1499) == 0);
      bus.i_clr_char  = 8'($urandom);
      step();
    end
    idle_inputs();
    wait_idle(1'b0);

`ifdef TEXT_ARB_CLEAR_EN
    // Reset in the middle of a clear, then a fresh clear from address 0.
    bus.i_clr_start = 1'b1;
    bus.i_clr_char  = 8'h55;
    step();
    bus.i_clr_start = 1'b0;
    step();
    chk("clr_first_addr", bus.o_ram_addr, 0);
    repeat (1000) step();
    chk("clr_addr_1000", bus.o_ram_addr, 1000);
    rstn = 1'b0;
    #1;
    chk("abort_busy", bus.o_clr_busy, 0);
    chk("abort_ready", bus.o_wr_ready, 1);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("abort_no_write", bus.o_ram_ce, 0);
    end
    rstn = 1'b1;
    step();
    bus.i_clr_start = 1'b1;
    bus.i_clr_char  = 8'h66;
    step();
    bus.i_clr_start = 1'b0;
    step();
    chk("restart_we", bus.o_ram_we, 1);
    chk("restart_addr", bus.o_ram_addr, 0);
    chk("restart_data", bus.o_ram_wdata, 8'h66);
    wait_idle(1'b1);
    read_lit("restart_fill", 11'd1500, 8'h66);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/text_ram_arbiter.md
# text_ram_arbiter

Single-port arbiter and sequencer for the text-mode character RAM (60×34 cells, 8-bit codes) behind the 8×8 character generator. It shares the RAM among three requesters in fixed priority: the display scan-out read, a screen-clear fill engine, and a host write port buffered by a one-entry skid register. It sits between the pixel-clock display pipeline and the block RAM primitive, in the LCD_CLK domain.

## Interface

Clock is `i_clk`; reset is `i_rstn`, asynchronous and active-low. One clock domain only.

Parameters:
- `ADDR_W`, 11, cell address width
- `DATA_W`, 8, character code width
- `CELLS`, 2040, number of cells cleared; valid addresses 0..CELLS-1

Ports:
- `i_clk  in  1` pixel clock
- `i_rstn  in  1` async active-low reset
- `i_rd_en  in  1` display read request this cycle
- `i_rd_addr  in  ADDR_W` display read address
- `o_rd_data  out  DATA_W` display read data, equals `i_ram_rdata`
- `i_wr_valid  in  1` host write valid
- `i_wr_addr  in  ADDR_W` host write address
- `i_wr_data  in  DATA_W` host write data
- `o_wr_ready  out  1` host write accepted when high together with valid
- `i_clr_start  in  1` single-cycle pulse to request a screen clear
- `i_clr_char  in  DATA_W` fill code, sampled with `i_clr_start`
- `o_clr_busy  out  1` clear pending or running
- `o_ram_ce  out  1`, `o_ram_we  out  1`, `o_ram_addr  out  ADDR_W`, `o_ram_wdata  out  DATA_W` RAM port
- `i_ram_rdata  in  DATA_W` RAM synchronous read data

## Operation

- Per-cycle priority:
  1. `i_rd_en`: read `i_rd_addr`.
  2. CLR_RUN: write fill char at the clear counter.
  3. Buffered host write.
  4. Otherwise `o_ram_ce`=0.
- RAM port outputs are a combinational mux of the selected grant. `o_ram_we`=1 only for grants 2 and 3.
- Host skid buffer (one entry):
  - `o_wr_ready` = buffer empty AND state IDLE.
  - A write is accepted on valid&ready and retires on its first free cycle.
  - A retire and a new accept in the same cycle is not possible, because ready is low while the buffer is full.
- State machine:
  - IDLE: `i_clr_start` latches `i_clr_char` and goes to CLR_WAIT.
  - CLR_WAIT: lets an already-buffered write retire first, so acceptance order is preserved. Goes to CLR_RUN when the buffer is empty.
  - CLR_RUN: the counter increments only on cycles the RAM grant is given. When the write at CELLS-1 is issued, goes to IDLE and the counter clears to 0.
- `o_clr_busy` = state ≠ IDLE. `i_clr_start` outside IDLE is ignored, and `i_clr_char` is not re-sampled.
- A simultaneous `i_clr_start` and valid host write in IDLE: the write is accepted (ready was high), then the clear runs after it retires.
- Addresses ≥ CELLS are passed through unchecked.

## Timing

- Display read latency: exactly 1 cycle from `i_rd_en` to `o_rd_data`, never stalled.
- Host write latency: at least 1 cycle from accept to RAM write. It is unbounded while `i_rd_en` stays high.
- Clear duration: CELLS free cycles. `o_clr_busy` rises the cycle after `i_clr_start` and falls the cycle after the last fill write.
- Reset values:
  - state IDLE, buffer empty, counter 0, latched fill char 0
  - `o_wr_ready`=1, `o_clr_busy`=0, `o_ram_ce`=0 (with `i_rd_en` low)
- Reset mid-clear aborts immediately. Memory is left partially filled and the buffered write is discarded.

## Configuration

- `TEXT_ARB_CLEAR_EN` defined: clear engine and the CLR_WAIT/CLR_RUN states are built.
- Not defined:
  - `i_clr_start` and `i_clr_char` are ignored.
  - `o_clr_busy` is tied 0.
  - The FSM reduces to IDLE only, and the host buffer drains on any free cycle.

## Structure

- Shared package `text_pkg`:
  - `TEXT_COLS`=60, `TEXT_ROWS`=34, `CELLS`=TEXT_COLS*TEXT_ROWS
  - address/data width constants
  - FSM state enumeration (IDLE, CLR_WAIT, CLR_RUN)
- Natural sub-module: `text_wr_skid`, the one-entry valid/ready buffer with a retire strobe input. The arbiter mux and FSM stay in the top module.

## Test plan

- Display only: `i_rd_en`=1 at addr 5 with RAM[5]=0x41 -> `o_rd_data`=0x41 one cycle later, `o_ram_we`=0 throughout.
- Host write during continuous reads: valid at addr 12, data 0x58 while `i_rd_en`=1 for 10 cycles -> ready drops after accept, and the RAM write of 0x58 to 12 occurs on the first cycle `i_rd_en`=0.
- Clear: pulse `i_clr_start` with 0x20, `i_rd_en` 50% duty -> exactly 2040 writes of 0x20 to addresses 0..2039, in order. Busy is high for the duration, and ready is 0 throughout.
- Ordering: a buffered write to addr 3 (0x7A) is pending when a clear starts -> addr 3 is written with 0x7A before the fill, so the final value is 0x20.
- Reset at clear counter 1000 -> busy=0, ready=1, no further writes; a new clear restarts at address 0.
- Macro undefined: `i_clr_start` pulse -> busy stays 0, no fill writes, and host writes proceed normally.
